// File: rtl/adder_arb_pkg.sv
// Shared definitions for the adder round-robin arbiter slice: adder latency,
// id-width helper and the result FIFO entry layout.
package adder_arb_pkg;

    // Cycles from adder valid_i to valid_o; the id pipeline and credit window follow it
    localparam int ADDER_LATENCY = 2;

    // Default configuration the FIFO entry layout is sized for
    localparam int DEFAULT_WIDTH   = 4;
    localparam int DEFAULT_NUM_REQ = 4;

    // Index width that never collapses to zero bits
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEFAULT_ID_W = clog2_min1(DEFAULT_NUM_REQ);

    // One buffered result: requester index plus the carry-extended sum
    typedef struct packed {
        logic [DEFAULT_ID_W-1:0]  id;
        logic [DEFAULT_WIDTH:0]   sum;
    } fifo_entry_t;

endpackage

// File: rtl/adder_result_fifo.sv
// Synchronous result FIFO with occupancy count. Reads are combinational from
// the head entry and forced to zero while empty so outputs are clean after reset.
module adder_result_fifo
    import adder_arb_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fifo_entry_t,
    localparam int PTR_W   = clog2_min1(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output entry_t           pop_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
    logic [CNT_W-1:0] count_d, count_q;
    logic             do_push, do_pop;

    // Accept operations only when legal; pointers wrap at DEPTH, which need not be a power of two
    always_comb begin
        do_push  = push && (count_q != CNT_W'(DEPTH));
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset since the read side is masked while empty
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/adder_valid_io.sv
// Two-stage pipelined unsigned adder with a valid flag, no backpressure.
// The sum is WIDTH+1 bits wide so the carry lands in the MSB.
module adder_valid_io #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             valid_o,
    output logic [WIDTH:0]   sum_o
);

    logic [1:0]     valid_d, valid_q;
    logic [WIDTH:0] sum1_d, sum1_q;
    logic [WIDTH:0] sum2_d, sum2_q;

    // Stage 1 performs the add, stage 2 only re-times it to reach the fixed latency
    always_comb begin
        valid_d = {valid_q[0], valid_i};
        sum1_d  = {1'b0, data1_i} + {1'b0, data2_i};
        sum2_d  = sum1_q;
    end

    // Pipeline registers, cleared by the active-high reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            sum1_q  <= '0;
            sum2_q  <= '0;
        end else begin
            valid_q <= valid_d;
            sum1_q  <= sum1_d;
            sum2_q  <= sum2_d;
        end
    end

    assign valid_o = valid_q[1];
    assign sum_o   = sum2_q;

endmodule

// File: rtl/adder_rr_arbiter.sv
// Shares one adder_valid_io among NUM_REQ requesters, tags each result with the
// requester index and buffers results in a credit-protected FIFO.
// Build option: ADDER_RR_ARBITER_FIXED_PRIO_EN selects fixed lowest-index priority
// instead of round-robin (pointer then stays at 0).
module adder_rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int  WIDTH      = 4,
    parameter int  NUM_REQ    = 4,
    parameter int  FIFO_DEPTH = 4,
    localparam int ID_W       = clog2_min1(NUM_REQ),
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       s_valid,
    output logic [NUM_REQ-1:0]       s_ready,
    input  logic [NUM_REQ*WIDTH-1:0] s_data1,
    input  logic [NUM_REQ*WIDTH-1:0] s_data2,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [WIDTH:0]           m_data,
    output logic [ID_W-1:0]          m_id,
    output logic                     busy
);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [WIDTH:0]  sum;
    } entry_t;

    logic                                run_d, run_q;
    logic [ID_W-1:0]                     rr_d, rr_q;
    logic [ADDER_LATENCY-1:0]            issue_d, issue_q;
    logic [ADDER_LATENCY-1:0][ID_W-1:0]  id_d, id_q;
    logic [ID_W-1:0]                     grant_idx;
    logic                                grant_found;
    logic                                credit_ok;
    logic                                handshake;
    int                                  inflight;
    logic [WIDTH-1:0]                    op1, op2;
    logic                                fifo_push;
    logic [WIDTH:0]                      adder_sum;
    entry_t                              push_entry, pop_entry;
    logic                                fifo_empty;
    logic [CNT_W-1:0]                    fifo_count;

    // Grant is the first valid requester at or above the pointer, wrapping around
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && s_valid[(int'(rr_q) + k) % NUM_REQ]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'((int'(rr_q) + k) % NUM_REQ);
            end
        end
    end

    // Credit counts buffered and in-flight results; a same-cycle pop is deliberately ignored
    always_comb begin
        inflight = 0;
        for (int k = 0; k < ADDER_LATENCY; k++) begin
            inflight = inflight + int'(issue_q[k]);
        end
        credit_ok = (int'(fifo_count) + inflight) < FIFO_DEPTH;
        s_ready   = '0;
        if (run_q && grant_found && credit_ok) begin
            s_ready[grant_idx] = 1'b1;
        end
        handshake = |(s_valid & s_ready);
        op1       = s_data1[grant_idx*WIDTH +: WIDTH];
        op2       = s_data2[grant_idx*WIDTH +: WIDTH];
    end

    // Next-state for pointer, issue history and the id pipeline that tracks the adder
    always_comb begin
        run_d      = 1'b1;
`ifdef ADDER_RR_ARBITER_FIXED_PRIO_EN
        rr_d       = '0;
`else
        rr_d       = rr_q;
        if (handshake) begin
            rr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
`endif
        issue_d[0] = handshake;
        id_d[0]    = grant_idx;
        for (int k = 1; k < ADDER_LATENCY; k++) begin
            issue_d[k] = issue_q[k-1];
            id_d[k]    = id_q[k-1];
        end
    end

    // Arbiter state; run_q keeps s_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q   <= 1'b0;
            rr_q    <= '0;
            issue_q <= '0;
            id_q    <= '0;
        end else begin
            run_q   <= run_d;
            rr_q    <= rr_d;
            issue_q <= issue_d;
            id_q    <= id_d;
        end
    end

    adder_valid_io #(
        .WIDTH   (WIDTH)
    ) u_adder (
        .clk     (clk),
        .reset   (~reset_n),
        .valid_i (handshake),
        .data1_i (op1),
        .data2_i (op2),
        .valid_o (fifo_push),
        .sum_o   (adder_sum)
    );

    assign push_entry.id  = id_q[ADDER_LATENCY-1];
    assign push_entry.sum = adder_sum;

    adder_result_fifo #(
        .DEPTH     (FIFO_DEPTH),
        .entry_t   (entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (m_ready),
        .pop_data  (pop_entry),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = pop_entry.sum;
    assign m_id    = pop_entry.id;
    assign busy    = !fifo_empty || (|issue_q);

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed bench for adder_rr_arbiter: table of single operations plus
// hand-written sequences for fairness, backpressure, grant hold and reset.
module tb_adder_rr_arbiter;

    localparam int WIDTH      = 4;
    localparam int NUM_REQ    = 4;
    localparam int FIFO_DEPTH = 4;

    typedef struct {
        int req;
        int a;
        int b;
        int expSum;
        int expId;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  s_valid;
    logic [3:0]  s_ready;
    logic [15:0] s_data1;
    logic [15:0] s_data2;
    logic        m_valid;
    logic        m_ready;
    logic [4:0]  m_data;
    logic [1:0]  m_id;
    logic        busy;

    int totalChecks = 0;
    int failCount   = 0;
    int expGrants[$];
    int expSums[$];
    int expIds[$];
    int firstOut;
    int lastOut;
    int outCount;
    vec_t vecs[8];

    always #5 clk = ~clk;

    adder_rr_arbiter #(
        .WIDTH      (WIDTH),
        .NUM_REQ    (NUM_REQ),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data1    (s_data1),
        .s_data2    (s_data2),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_id       (m_id),
        .busy       (busy)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        totalChecks++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic ready);
        s_valid = valid;
        m_ready = ready;
    endtask

    task automatic setOperands(input int req, input int a, input int b);
        s_data1[req*4 +: 4] = 4'(a);
        s_data2[req*4 +: 4] = 4'(b);
    endtask

    task automatic expectResult(input int sum, input int id);
        expSums.push_back(sum);
        expIds.push_back(id);
    endtask

    // Runs a fixed number of cycles: drive at negedge, observe 1 time unit later
    task automatic runPhase(input logic [3:0] pattern, input logic ready, input int maxIssues,
                            input int cycles, input string tag);
        int issued = 0;
        firstOut = -1;
        lastOut  = -1;
        outCount = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            applyStimulus((issued < maxIssues) ? pattern : 4'b0000, ready);
            #1;
            if (m_valid && m_ready) begin
                if (expSums.size() == 0) begin
                    checkOutput({tag, " unexpected result"}, 1, 0);
                end else begin
                    checkOutput({tag, " m_data"}, int'(m_data), expSums.pop_front());
                    checkOutput({tag, " m_id"}, int'(m_id), expIds.pop_front());
                end
                if (firstOut < 0) firstOut = c;
                lastOut = c;
                outCount++;
            end
            if (s_ready != 4'b0000) begin
                if (expGrants.size() == 0) begin
                    checkOutput({tag, " unexpected grant"}, int'(s_ready), 0);
                end else begin
                    checkOutput({tag, " s_ready"}, int'(s_ready), 1 << expGrants.pop_front());
                end
                issued++;
            end
        end
        checkOutput({tag, " grants outstanding"}, expGrants.size(), 0);
        checkOutput({tag, " results outstanding"}, expSums.size(), 0);
        expGrants.delete();
        expSums.delete();
        expIds.delete();
    endtask

    // A push must never land on a full FIFO
    always @(negedge clk) begin
        if (reset_n && dut.fifo_push) begin
            checkOutput("push into full FIFO", int'(dut.fifo_count == 3'(FIFO_DEPTH)), 0);
        end
    end

    initial begin
        int stale;

        vecs[0] = '{req: 2, a: 4,  b: 9,  expSum: 13, expId: 2};
        vecs[1] = '{req: 0, a: 0,  b: 0,  expSum: 0,  expId: 0};
        vecs[2] = '{req: 1, a: 15, b: 15, expSum: 30, expId: 1};
        vecs[3] = '{req: 0, a: 7,  b: 8,  expSum: 15, expId: 0};
        vecs[4] = '{req: 2, a: 10, b: 5,  expSum: 15, expId: 2};
        vecs[5] = '{req: 1, a: 8,  b: 8,  expSum: 16, expId: 1};
        vecs[6] = '{req: 3, a: 0,  b: 15, expSum: 15, expId: 3};
        vecs[7] = '{req: 3, a: 15, b: 1,  expSum: 16, expId: 3};

        s_data1 = '0;
        s_data2 = '0;
        reset_n = 1'b0;
        applyStimulus(4'hF, 1'b0);

        // Reset: all requesters valid but nothing may be granted
        repeat (2) @(negedge clk);
        checkOutput("reset s_ready", int'(s_ready), 0);
        checkOutput("reset m_valid", int'(m_valid), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset m_data", int'(m_data), 0);
        checkOutput("reset m_id", int'(m_id), 0);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("first grant after reset", int'(s_ready), 1);
        applyStimulus(4'b0000, 1'b1);

        // Single operations; the first is req2 4+9
        for (int v = 0; v < 8; v++) begin
            setOperands(vecs[v].req, vecs[v].a, vecs[v].b);
            expGrants.push_back(vecs[v].req);
            expectResult(vecs[v].expSum, vecs[v].expId);
            runPhase(4'(1 << vecs[v].req), 1'b1, 1, 5, $sformatf("vec%0d", v));
            checkOutput($sformatf("vec%0d latency", v), firstOut, 3);
        end

        // Fairness: everyone valid, results drain one per cycle
        for (int i = 0; i < 4; i++) setOperands(i, i, i + 1);
        for (int n = 0; n < 8; n++) begin
`ifdef ADDER_RR_ARBITER_FIXED_PRIO_EN
            expGrants.push_back(0);
            expectResult(1, 0);
`else
            expGrants.push_back(n % 4);
            expectResult(2 * (n % 4) + 1, n % 4);
`endif
        end
        runPhase(4'hF, 1'b1, 8, 12, "fair");
        checkOutput("fair result count", outCount, 8);
        checkOutput("fair back-to-back", lastOut - firstOut, 7);

        // Backpressure: credit admits exactly FIFO_DEPTH issues
        setOperands(1, 15, 15);
        repeat (4) expGrants.push_back(1);
        runPhase(4'b0010, 1'b0, 10, 8, "bp");
        checkOutput("bp s_ready blocked", int'(s_ready), 0);
        checkOutput("bp m_valid", int'(m_valid), 1);
        checkOutput("bp m_data", int'(m_data), 30);
        checkOutput("bp m_id", int'(m_id), 1);
        checkOutput("bp busy", int'(busy), 1);

        // Grant hold: req3 waits without credit, req0 joins later
        setOperands(3, 5, 6);
        setOperands(0, 1, 1);
        runPhase(4'b1000, 1'b0, 4, 3, "hold3");
        runPhase(4'b1001, 1'b0, 4, 3, "hold30");
        checkOutput("hold m_data stable", int'(m_data), 30);
        checkOutput("hold m_id stable", int'(m_id), 1);
        repeat (4) expectResult(30, 1);
`ifdef ADDER_RR_ARBITER_FIXED_PRIO_EN
        expGrants.push_back(0);
        expGrants.push_back(0);
        expectResult(2, 0);
        expectResult(2, 0);
`else
        expGrants.push_back(3);
        expGrants.push_back(0);
        expectResult(11, 3);
        expectResult(2, 0);
`endif
        runPhase(4'b1001, 1'b1, 2, 12, "drain");
        checkOutput("drain result count", outCount, 6);
        checkOutput("drain idle busy", int'(busy), 0);

        // Reset while two operations are in the adder
        setOperands(0, 3, 3);
        setOperands(1, 1, 2);
        @(negedge clk);
        applyStimulus(4'b0011, 1'b1);
        @(negedge clk);
        @(negedge clk);
        applyStimulus(4'b0000, 1'b1);
        reset_n = 1'b0;
        #1;
        checkOutput("midreset m_valid", int'(m_valid), 0);
        checkOutput("midreset busy", int'(busy), 0);
        checkOutput("midreset s_ready", int'(s_ready), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (m_valid) stale++;
        end
        checkOutput("stale results after reset", stale, 0);
        applyStimulus(4'b0110, 1'b1);
        #1;
        checkOutput("pointer cleared by reset", int'(s_ready), 2);
        applyStimulus(4'b0000, 1'b1);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", totalChecks, failCount);
        $finish;
    end

endmodule
